ahb_bus_arbiter: RTL

- Multi-master AHB-Lite arbiter; the sequencing/ownership controller for the shared system bus.
- Decides which master drives the address phase.
- Produces address-phase and data-phase master IDs. The master-to-slave address mux consumes the address-phase ID; the slave-to-master response/read-data path routing consumes the data-phase ID.
- Round-robin by default. Fixed-length bursts and locked sequences are never broken.

---
 rtl/ahb_bus_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - AHB-Lite multi-master arbiter with burst/lock hold.
// Round-robin by default; define AHB_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MID_W       = 2,
  parameter int PARK_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MID_W-1:0]       HMASTER,
  output logic [MID_W-1:0]       HMASTER_D,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam int PAD_W = 2 ** MID_W;
  localparam logic [MID_W-1:0]       PARK_ID  = MID_W'(PARK_MASTER);
  localparam logic [NUM_MASTERS-1:0] PARK_GNT = NUM_MASTERS'(1) << PARK_MASTER;

  typedef enum logic [1:0] {
    ST_ARB,
    ST_BURST,
    ST_LOCKED
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MID_W-1:0]       mst_q, mst_d;
  logic [MID_W-1:0]       mst_dp_q, mst_dp_d;
  logic                   mlock_q, mlock_d;

  logic [PAD_W-1:0]       lock_pad;
  logic [MID_W-1:0]       gnt_idx;
  logic [MID_W-1:0]       win_idx;
  logic [3:0]             load_val;
  logic                   rearb;

  // Widened so indexing by any MID_W-bit ID stays in range.
  assign lock_pad = PAD_W'(HLOCK);

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) gnt_idx = MID_W'(i);
    end
  end

`ifdef AHB_ARB_FIXED_PRIO_EN
  always_comb begin
    win_idx = PARK_ID;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (HBUSREQ[i]) win_idx = MID_W'(i);
    end
  end
`else
  logic [MID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [MID_W-1:0] cand;
  logic             found;

  // Search begins just after the last winner and wraps, so the owner comes last.
  always_comb begin
    win_idx = PARK_ID;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = MID_W'((int'(rr_ptr_q) + k) % NUM_MASTERS);
      if (!found && HBUSREQ[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (rearb) rr_ptr_d = win_idx;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) rr_ptr_q <= PARK_ID;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    case (HBURST)
      3'b010, 3'b011: load_val = 4'd3;
      3'b100, 3'b101: load_val = 4'd7;
      3'b110, 3'b111: load_val = 4'd15;
      default:        load_val = 4'd0;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    state_d  = state_q;
    grant_d  = grant_q;
    mst_d    = mst_q;
    mst_dp_d = mst_dp_q;
    mlock_d  = mlock_q;
    if (HREADY) begin
      if (HTRANS == TR_NONSEQ) begin
        cnt_d = load_val;
      end else if (HTRANS == TR_SEQ && cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end

      if (HTRANS == TR_NONSEQ) begin
        if (lock_pad[mst_q])        state_d = ST_LOCKED;
        else if (load_val != 4'd0)  state_d = ST_BURST;
        else                        state_d = ST_ARB;
      end else if (state_q == ST_BURST && HTRANS == TR_SEQ && cnt_d == 4'd0) begin
        state_d = ST_ARB;
      end else if (state_q == ST_LOCKED && HTRANS == TR_IDLE && !lock_pad[mst_q]) begin
        state_d = ST_ARB;
      end

      mst_d    = gnt_idx;
      mst_dp_d = mst_q;
      mlock_d  = lock_pad[gnt_idx];
    end
    // Judged on the next state so the edge that starts a burst or lock never regrants.
    rearb = HREADY && (state_d == ST_ARB);
    if (rearb) grant_d = NUM_MASTERS'(1) << win_idx;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= ST_ARB;
      cnt_q    <= 4'd0;
      grant_q  <= PARK_GNT;
      mst_q    <= PARK_ID;
      mst_dp_q <= PARK_ID;
      mlock_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      mst_q    <= mst_d;
      mst_dp_q <= mst_dp_d;
      mlock_q  <= mlock_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = mst_q;
  assign HMASTER_D = mst_dp_q;
  assign HMASTLOCK = mlock_q;

endmodule
